// File: rtl/periph_axi_pkg.sv
// rtl/periph_axi_pkg.sv - shared widths and engine state encodings for the peripheral port arbiter
package periph_axi_pkg;

    localparam int NUM_MASTERS_DEF = 2;
    localparam int AW_W_DEF        = 44;
    localparam int W_W_DEF         = 73;
    localparam int B_W_DEF         = 6;
    localparam int AR_W_DEF        = 44;
    localparam int R_W_DEF         = 71;

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_e;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: lowest requester at or above the pointer, else lowest overall
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     grant_oh_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             grant_vld_o
);

    logic [N-1:0] upper_mask;
    logic [N-1:0] upper_req;

    always_comb begin
        upper_mask = '0;
        for (int i = 0; i < N; i++) begin
            upper_mask[i] = (IDX_W'(i) >= ptr_i);
        end
        upper_req = req_i & upper_mask;

        grant_idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) grant_idx_o = IDX_W'(i);
        end
        // Requesters at/after the pointer take precedence over the wrapped ones.
        for (int i = N - 1; i >= 0; i--) begin
            if (upper_req[i]) grant_idx_o = IDX_W'(i);
        end

        grant_vld_o = |req_i;
        grant_oh_o  = grant_vld_o ? (N'(1) << grant_idx_o) : '0;
    end

endmodule

// File: rtl/periph_axi_arbiter.sv
// rtl/periph_axi_arbiter.sv - shares one peripheral AXI-style port between NUM_MASTERS requesters,
// with independent single-outstanding write and read engines
module periph_axi_arbiter
    import periph_axi_pkg::*;
#(
    parameter int NUM_MASTERS = NUM_MASTERS_DEF,
    parameter int AW_W        = AW_W_DEF,
    parameter int W_W         = W_W_DEF,
    parameter int B_W         = B_W_DEF,
    parameter int AR_W        = AR_W_DEF,
    parameter int R_W         = R_W_DEF,
    parameter int W_LAST_BIT  = 0,
    parameter int R_LAST_BIT  = 0
) (
    input  logic                          clk,
    input  logic                          reset_bar,
    input  logic [NUM_MASTERS-1:0]        s_aw_valid,
    output logic [NUM_MASTERS-1:0]        s_aw_ready,
    input  logic [NUM_MASTERS*AW_W-1:0]   s_aw_msg,
    input  logic [NUM_MASTERS-1:0]        s_w_valid,
    output logic [NUM_MASTERS-1:0]        s_w_ready,
    input  logic [NUM_MASTERS*W_W-1:0]    s_w_msg,
    output logic [NUM_MASTERS-1:0]        s_b_valid,
    input  logic [NUM_MASTERS-1:0]        s_b_ready,
    output logic [NUM_MASTERS*B_W-1:0]    s_b_msg,
    input  logic [NUM_MASTERS-1:0]        s_ar_valid,
    output logic [NUM_MASTERS-1:0]        s_ar_ready,
    input  logic [NUM_MASTERS*AR_W-1:0]   s_ar_msg,
    output logic [NUM_MASTERS-1:0]        s_r_valid,
    input  logic [NUM_MASTERS-1:0]        s_r_ready,
    output logic [NUM_MASTERS*R_W-1:0]    s_r_msg,
    output logic                          m_aw_valid,
    input  logic                          m_aw_ready,
    output logic [AW_W-1:0]               m_aw_msg,
    output logic                          m_w_valid,
    input  logic                          m_w_ready,
    output logic [W_W-1:0]                m_w_msg,
    input  logic                          m_b_valid,
    output logic                          m_b_ready,
    input  logic [B_W-1:0]                m_b_msg,
    output logic                          m_ar_valid,
    input  logic                          m_ar_ready,
    output logic [AR_W-1:0]               m_ar_msg,
    input  logic                          m_r_valid,
    output logic                          m_r_ready,
    input  logic [R_W-1:0]                m_r_msg
);

    localparam int N     = NUM_MASTERS;
    localparam int IDX_W = $clog2(N);

    function automatic logic [IDX_W-1:0] ptr_next(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(N - 1)) ? '0 : idx + IDX_W'(1);
    endfunction

    logic [AW_W-1:0] aw_msg_arr [N];
    logic [W_W-1:0]  w_msg_arr  [N];
    logic [AR_W-1:0] ar_msg_arr [N];

    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign aw_msg_arr[g] = s_aw_msg[g*AW_W +: AW_W];
        assign w_msg_arr[g]  = s_w_msg[g*W_W +: W_W];
        assign ar_msg_arr[g] = s_ar_msg[g*AR_W +: AR_W];
    end

    wr_state_e        wr_q, wr_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d, wr_ptr_q, wr_ptr_d;
    logic [N-1:0]     wr_oh_q, wr_oh_d;
    rd_state_e        rd_q, rd_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d, rd_ptr_q, rd_ptr_d;
    logic [N-1:0]     rd_oh_q, rd_oh_d;

    logic [N-1:0]     aw_gnt_oh, ar_gnt_oh;
    logic [IDX_W-1:0] aw_gnt_idx, ar_gnt_idx;
    logic             aw_gnt_vld, ar_gnt_vld;

    rr_arbiter #(.N(N), .IDX_W(IDX_W)) u_aw_arb (
        .req_i       (s_aw_valid),
        .ptr_i       (wr_ptr_q),
        .grant_oh_o  (aw_gnt_oh),
        .grant_idx_o (aw_gnt_idx),
        .grant_vld_o (aw_gnt_vld)
    );

    rr_arbiter #(.N(N), .IDX_W(IDX_W)) u_ar_arb (
        .req_i       (s_ar_valid),
        .ptr_i       (rd_ptr_q),
        .grant_oh_o  (ar_gnt_oh),
        .grant_idx_o (ar_gnt_idx),
        .grant_vld_o (ar_gnt_vld)
    );

    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            wr_q     <= W_IDLE;
            wr_idx_q <= '0;
            wr_oh_q  <= '0;
            wr_ptr_q <= '0;
        end else begin
            wr_q     <= wr_d;
            wr_idx_q <= wr_idx_d;
            wr_oh_q  <= wr_oh_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    always_comb begin
        wr_d       = wr_q;
        wr_idx_d   = wr_idx_q;
        wr_oh_d    = wr_oh_q;
        wr_ptr_d   = wr_ptr_q;
        s_aw_ready = '0;
        s_w_ready  = '0;
        s_b_valid  = '0;
        s_b_msg    = '0;
        m_aw_valid = 1'b0;
        m_aw_msg   = '0;
        m_w_valid  = 1'b0;
        m_w_msg    = '0;
        m_b_ready  = 1'b0;
        case (wr_q)
            // Grant is only registered here so no requester valid reaches m_aw_valid combinationally.
            W_IDLE: begin
                if (aw_gnt_vld) begin
                    wr_idx_d = aw_gnt_idx;
                    wr_oh_d  = aw_gnt_oh;
                    wr_d     = W_ADDR;
                end
            end
            W_ADDR: begin
                m_aw_valid = |(s_aw_valid & wr_oh_q);
                m_aw_msg   = m_aw_valid ? aw_msg_arr[wr_idx_q] : '0;
                s_aw_ready = wr_oh_q & {N{m_aw_ready}};
                if (m_aw_valid && m_aw_ready) wr_d = W_DATA;
            end
            W_DATA: begin
                m_w_valid = |(s_w_valid & wr_oh_q);
                m_w_msg   = m_w_valid ? w_msg_arr[wr_idx_q] : '0;
                s_w_ready = wr_oh_q & {N{m_w_ready}};
                if (m_w_valid && m_w_ready && m_w_msg[W_LAST_BIT]) wr_d = W_RESP;
            end
            W_RESP: begin
                s_b_valid = wr_oh_q & {N{m_b_valid}};
                for (int i = 0; i < N; i++) begin
                    if (wr_oh_q[i] && m_b_valid) s_b_msg[i*B_W +: B_W] = m_b_msg;
                end
                m_b_ready = |(s_b_ready & wr_oh_q);
                if (m_b_valid && m_b_ready) begin
                    wr_d     = W_IDLE;
                    wr_ptr_d = ptr_next(wr_idx_q);
                end
            end
            default: wr_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            rd_q     <= R_IDLE;
            rd_idx_q <= '0;
            rd_oh_q  <= '0;
            rd_ptr_q <= '0;
        end else begin
            rd_q     <= rd_d;
            rd_idx_q <= rd_idx_d;
            rd_oh_q  <= rd_oh_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_comb begin
        rd_d       = rd_q;
        rd_idx_d   = rd_idx_q;
        rd_oh_d    = rd_oh_q;
        rd_ptr_d   = rd_ptr_q;
        s_ar_ready = '0;
        s_r_valid  = '0;
        s_r_msg    = '0;
        m_ar_valid = 1'b0;
        m_ar_msg   = '0;
        m_r_ready  = 1'b0;
        case (rd_q)
            R_IDLE: begin
                if (ar_gnt_vld) begin
                    rd_idx_d = ar_gnt_idx;
                    rd_oh_d  = ar_gnt_oh;
                    rd_d     = R_ADDR;
                end
            end
            R_ADDR: begin
                m_ar_valid = |(s_ar_valid & rd_oh_q);
                m_ar_msg   = m_ar_valid ? ar_msg_arr[rd_idx_q] : '0;
                s_ar_ready = rd_oh_q & {N{m_ar_ready}};
                if (m_ar_valid && m_ar_ready) rd_d = R_DATA;
            end
            R_DATA: begin
                s_r_valid = rd_oh_q & {N{m_r_valid}};
                for (int i = 0; i < N; i++) begin
                    if (rd_oh_q[i] && m_r_valid) s_r_msg[i*R_W +: R_W] = m_r_msg;
                end
                m_r_ready = |(s_r_ready & rd_oh_q);
                if (m_r_valid && m_r_ready && m_r_msg[R_LAST_BIT]) begin
                    rd_d     = R_IDLE;
                    rd_ptr_d = ptr_next(rd_idx_q);
                end
            end
            default: rd_d = R_IDLE;
        endcase
    end

    // A granted requester must hold its address valid until it is accepted.
    aw_valid_held: assert property (@(posedge clk) disable iff (!reset_bar)
        (wr_q == W_ADDR) |-> |(s_aw_valid & wr_oh_q));
    ar_valid_held: assert property (@(posedge clk) disable iff (!reset_bar)
        (rd_q == R_ADDR) |-> |(s_ar_valid & rd_oh_q));

endmodule

// File: tb/tb_periph_axi_arbiter.sv
// tb/tb_periph_axi_arbiter.sv - scoreboard bench for periph_axi_arbiter
module tb_periph_axi_arbiter;

    localparam int N    = 2;
    localparam int AW_W = 44;
    localparam int W_W  = 73;
    localparam int B_W  = 6;
    localparam int AR_W = 44;
    localparam int R_W  = 71;

    logic clk = 1'b0;
    logic reset_bar;
    logic [N-1:0]      s_aw_valid, s_aw_ready, s_w_valid, s_w_ready, s_b_valid, s_b_ready;
    logic [N-1:0]      s_ar_valid, s_ar_ready, s_r_valid, s_r_ready;
    logic [N*AW_W-1:0] s_aw_msg;
    logic [N*W_W-1:0]  s_w_msg;
    logic [N*B_W-1:0]  s_b_msg;
    logic [N*AR_W-1:0] s_ar_msg;
    logic [N*R_W-1:0]  s_r_msg;
    logic m_aw_valid, m_aw_ready, m_w_valid, m_w_ready, m_b_valid, m_b_ready;
    logic m_ar_valid, m_ar_ready, m_r_valid, m_r_ready;
    logic [AW_W-1:0] m_aw_msg;
    logic [W_W-1:0]  m_w_msg;
    logic [B_W-1:0]  m_b_msg;
    logic [AR_W-1:0] m_ar_msg;
    logic [R_W-1:0]  m_r_msg;
    logic [5*N+4:0]  vr_all;

    assign vr_all = {s_aw_ready, s_w_ready, s_ar_ready, s_b_valid, s_r_valid,
                     m_aw_valid, m_w_valid, m_ar_valid, m_b_ready, m_r_ready};

    periph_axi_arbiter #(
        .NUM_MASTERS(N), .AW_W(AW_W), .W_W(W_W), .B_W(B_W), .AR_W(AR_W), .R_W(R_W),
        .W_LAST_BIT(0), .R_LAST_BIT(0)
    ) dut (
        .clk(clk), .reset_bar(reset_bar),
        .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_msg(s_aw_msg),
        .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_msg(s_w_msg),
        .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_msg(s_b_msg),
        .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_msg(s_ar_msg),
        .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_msg(s_r_msg),
        .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_msg(m_aw_msg),
        .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_msg(m_w_msg),
        .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_msg(m_b_msg),
        .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_msg(m_ar_msg),
        .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_msg(m_r_msg)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [127:0] exp_aw_q[$], exp_w_q[$], exp_ar_q[$], exp_b_q[$], exp_r_q[$];
    int           exp_b_own[$], exp_r_own[$];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_bar) begin
            if (m_aw_valid && m_aw_ready) begin
                if (exp_aw_q.size() > 0) chk("aw_msg", 128'(m_aw_msg), exp_aw_q.pop_front());
                else chk("aw_unexpected", 128'(exp_aw_q.size()), 128'd1);
            end
            if (m_w_valid && m_w_ready) begin
                if (exp_w_q.size() > 0) chk("w_msg", 128'(m_w_msg), exp_w_q.pop_front());
                else chk("w_unexpected", 128'(exp_w_q.size()), 128'd1);
            end
            if (m_ar_valid && m_ar_ready) begin
                if (exp_ar_q.size() > 0) chk("ar_msg", 128'(m_ar_msg), exp_ar_q.pop_front());
                else chk("ar_unexpected", 128'(exp_ar_q.size()), 128'd1);
            end
            for (int i = 0; i < N; i++) begin
                if (s_b_valid[i] && s_b_ready[i]) begin
                    if (exp_b_q.size() > 0) begin
                        chk("b_owner", 128'(i), 128'(exp_b_own.pop_front()));
                        chk("b_msg", 128'(s_b_msg[i*B_W +: B_W]), exp_b_q.pop_front());
                    end else chk("b_unexpected", 128'(exp_b_q.size()), 128'd1);
                end
                if (s_r_valid[i] && s_r_ready[i]) begin
                    if (exp_r_q.size() > 0) begin
                        chk("r_owner", 128'(i), 128'(exp_r_own.pop_front()));
                        chk("r_msg", 128'(s_r_msg[i*R_W +: R_W]), exp_r_q.pop_front());
                    end else chk("r_unexpected", 128'(exp_r_q.size()), 128'd1);
                end
            end
        end
    end

    task automatic wr_aw(input int m, input logic [AW_W-1:0] a);
        bit done;
        done = 1'b0;
        s_aw_msg[m*AW_W +: AW_W] = a;
        s_aw_valid[m] = 1'b1;
        exp_aw_q.push_back(128'(a));
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (s_aw_ready[m]) done = 1'b1;
        end
        chk("aw_wait", 128'(done), 128'd1);
        @(posedge clk); #1;
        s_aw_valid[m] = 1'b0;
        s_aw_msg[m*AW_W +: AW_W] = '0;
    endtask

    task automatic wr_w_beat(input int m, input logic [W_W-1:0] d);
        bit done;
        done = 1'b0;
        s_w_msg[m*W_W +: W_W] = d;
        s_w_valid[m] = 1'b1;
        exp_w_q.push_back(128'(d));
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (s_w_ready[m]) done = 1'b1;
        end
        chk("w_wait", 128'(done), 128'd1);
        @(posedge clk); #1;
        s_w_valid[m] = 1'b0;
        s_w_msg[m*W_W +: W_W] = '0;
    endtask

    task automatic rd_ar(input int m, input logic [AR_W-1:0] a);
        bit done;
        done = 1'b0;
        s_ar_msg[m*AR_W +: AR_W] = a;
        s_ar_valid[m] = 1'b1;
        exp_ar_q.push_back(128'(a));
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (s_ar_ready[m]) done = 1'b1;
        end
        chk("ar_wait", 128'(done), 128'd1);
        @(posedge clk); #1;
        s_ar_valid[m] = 1'b0;
        s_ar_msg[m*AR_W +: AR_W] = '0;
    endtask

    task automatic slave_b(input int o, input logic [B_W-1:0] b);
        bit done;
        logic [N-1:0] route;
        done  = 1'b0;
        route = '0;
        m_b_msg   = b;
        m_b_valid = 1'b1;
        exp_b_own.push_back(o);
        exp_b_q.push_back(128'(b));
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (m_b_ready) begin
                done  = 1'b1;
                route = s_b_valid;
            end
        end
        chk("b_wait", 128'(done), 128'd1);
        chk("b_route", 128'(route), 128'(1 << o));
        @(posedge clk); #1;
        m_b_valid = 1'b0;
        m_b_msg   = '0;
    endtask

    task automatic slave_r(input int o, input logic [R_W-1:0] r);
        bit done;
        logic [N-1:0] route;
        done  = 1'b0;
        route = '0;
        m_r_msg   = r;
        m_r_valid = 1'b1;
        exp_r_own.push_back(o);
        exp_r_q.push_back(128'(r));
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (m_r_ready) begin
                done  = 1'b1;
                route = s_r_valid;
            end
        end
        chk("r_wait", 128'(done), 128'd1);
        chk("r_route", 128'(route), 128'(1 << o));
        @(posedge clk); #1;
        m_r_valid = 1'b0;
        m_r_msg   = '0;
    endtask

    task automatic alternating_reads();
        int o, got;
        int cnt [2];
        logic [AR_W-1:0] base [2];
        base[0] = 44'hA00;
        base[1] = 44'hB00;
        cnt[0]  = 0;
        cnt[1]  = 0;
        s_ar_msg[0 +: AR_W]    = base[0];
        s_ar_msg[AR_W +: AR_W] = base[1];
        s_ar_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            o = k % 2;
            exp_ar_q.push_back(128'(base[o] + AR_W'(cnt[o])));
            got = -1;
            for (int c = 0; c < 50 && got < 0; c++) begin
                @(negedge clk);
                for (int i = 0; i < N; i++) if (s_ar_ready[i]) got = i;
            end
            chk("rd_grant_order", 128'(got), 128'(o));
            @(posedge clk); #1;
            cnt[o]++;
            s_ar_msg[o*AR_W +: AR_W] = base[o] + AR_W'(cnt[o]);
            slave_r(o, R_W'((32'hC0 + 16 * k) << 1));
            slave_r(o, R_W'(((32'hC1 + 16 * k) << 1) | 1));
        end
        s_ar_valid = '0;
        s_ar_msg   = '0;
    endtask

    task automatic backpressure();
        bit seen;
        logic [W_W-1:0] beat_a, beat_b;
        beat_a = W_W'(73'h5A5A_0000) | W_W'(2);
        beat_b = W_W'(73'h5A5A_0000) | W_W'(5);
        m_w_ready = 1'b0;
        fork
            begin
                wr_aw(0, 44'h055);
                wr_w_beat(0, beat_a);
                wr_w_beat(0, beat_b);
            end
            begin
                seen = 1'b0;
                for (int c = 0; c < 50 && !seen; c++) begin
                    @(negedge clk);
                    if (m_w_valid) seen = 1'b1;
                end
                chk("bp_w_seen", 128'(seen), 128'd1);
                for (int c = 0; c < 5; c++) begin
                    chk("bp_w_msg_stable", 128'(m_w_msg), 128'(beat_a));
                    chk("bp_w_ready_low", 128'(s_w_ready), 128'd0);
                    if (c < 4) @(negedge clk);
                end
                @(posedge clk); #1;
                m_w_ready = 1'b1;
            end
        join
        s_b_ready[0] = 1'b0;
        fork
            slave_b(0, 6'h07);
            begin
                @(negedge clk);
                for (int c = 0; c < 3; c++) begin
                    chk("bp_b_msg_stable", 128'(s_b_msg[0 +: B_W]), 128'h07);
                    chk("bp_b_msg_other", 128'(s_b_msg[B_W +: B_W]), 128'h0);
                    chk("bp_b_valid", 128'(s_b_valid), 128'b01);
                    chk("bp_b_mready_low", 128'(m_b_ready), 128'd0);
                    if (c < 2) @(negedge clk);
                end
                @(posedge clk); #1;
                s_b_ready[0] = 1'b1;
            end
        join
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        reset_bar  = 1'b0;
        s_aw_valid = '1;
        s_w_valid  = '1;
        s_ar_valid = '1;
        s_b_ready  = '1;
        s_r_ready  = '1;
        s_aw_msg   = {44'h222, 44'h111};
        s_w_msg    = '0;
        s_ar_msg   = {44'h444, 44'h333};
        m_aw_ready = 1'b0;
        m_ar_ready = 1'b0;
        m_w_ready  = 1'b1;
        m_b_valid  = 1'b1;
        m_r_valid  = 1'b1;
        m_b_msg    = 6'h3F;
        m_r_msg    = '1;

        // Reset held with everything asserted, then a grant one cycle after release.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs_zero", 128'(vr_all), 128'd0);
        chk("rst_b_msg_zero", 128'(s_b_msg), 128'd0);
        @(posedge clk); #1;
        reset_bar = 1'b1;
        @(negedge clk);
        chk("release_no_comb_grant", 128'(vr_all), 128'd0);
        @(negedge clk);
        chk("grant_aw_valid", 128'(m_aw_valid), 128'd1);
        chk("grant_aw_m0", 128'(m_aw_msg), 128'h111);
        chk("grant_ar_m0", 128'(m_ar_msg), 128'h333);
        chk("w_before_aw_stall", 128'(s_w_ready), 128'd0);
        chk("stray_b_ready", 128'(m_b_ready), 128'd0);
        chk("stray_r_ready", 128'(m_r_ready), 128'd0);
        #2 reset_bar = 1'b0;
        #1 chk("async_rst_outputs", 128'(vr_all), 128'd0);
        s_aw_valid = '0; s_w_valid = '0; s_ar_valid = '0;
        s_aw_msg = '0; s_ar_msg = '0;
        m_b_valid = 1'b0; m_r_valid = 1'b0; m_b_msg = '0; m_r_msg = '0;
        m_aw_ready = 1'b1; m_ar_ready = 1'b1;
        @(posedge clk); #1;
        reset_bar = 1'b1;

        // Single write from M0, three data beats.
        wr_aw(0, 44'h123);
        wr_w_beat(0, W_W'(32'h10) << 1);
        wr_w_beat(0, W_W'(32'h20) << 1);
        wr_w_beat(0, (W_W'(32'h30) << 1) | W_W'(1));
        slave_b(0, 6'h02);

        alternating_reads();

        // Concurrent write by M1 and read by M0.
        fork
            begin
                wr_aw(1, 44'h3AA);
                wr_w_beat(1, W_W'(73'h1_0001));
                slave_b(1, 6'h15);
            end
            begin
                rd_ar(0, 44'h4BB);
                slave_r(0, R_W'(71'h77_0001));
            end
            begin
                @(posedge clk);
                @(negedge clk);
                chk("concurrent_aw_ar", 128'({m_aw_valid, m_ar_valid}), 128'b11);
            end
        join

        backpressure();

        // Reset in the middle of a 4-beat write, then a clean write.
        wr_aw(0, 44'h0AB);
        wr_w_beat(0, W_W'(32'hE0) << 1);
        m_w_ready = 1'b0;
        s_w_msg[0 +: W_W] = W_W'(32'hE1) << 1;
        s_w_valid[0] = 1'b1;
        @(negedge clk);
        chk("mid_write_w_valid", 128'(m_w_valid), 128'd1);
        #2 reset_bar = 1'b0;
        #1 chk("mid_write_rst_outputs", 128'(vr_all), 128'd0);
        s_w_valid = '0;
        s_w_msg   = '0;
        m_w_ready = 1'b1;
        @(posedge clk); #1;
        reset_bar = 1'b1;
        s_aw_msg[0 +: AW_W] = 44'h0CD;
        s_aw_valid[0] = 1'b1;
        @(negedge clk);
        chk("post_rst_starts_idle", 128'(m_aw_valid), 128'd0);
        wr_aw(0, 44'h0CD);
        wr_w_beat(0, W_W'(73'h9));
        slave_b(0, 6'h01);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 128'(exp_aw_q.size() + exp_w_q.size() + exp_ar_q.size()
                                        + exp_b_q.size() + exp_r_q.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
